// File: rtl/servo_pkg.sv
// Shared types and default timing constants for the servo gate sequencer.
// 50 MHz system clock assumed for the default cycle counts.
package servo_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        CLOSED    = 2'd0,
        OPENING   = 2'd1,
        OPEN_HOLD = 2'd2,
        CLOSING   = 2'd3
    } servo_state_t;

    localparam int SERVO_SETTLE_CYCLES = 25_000_000;
    localparam int SERVO_HOLD_CYCLES   = 150_000_000;

endpackage

// File: rtl/servo_gate_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: searches from rr_ptr+1 (mod NREQ) for the
// first asserted request; the parent owns and updates the pointer.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             enable,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = IDX_W'((int'(rr_ptr) + off) % NREQ);
            if (enable && !grant_valid && req[idx]) begin
                grant_valid    = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/servo_gate_sequencer.sv
// Open/settle/hold/close sequencer in front of the 0/90 degree servo PWM block.
// Define SERVO_SEQ_RETRIGGER_EN to let requests during OPEN_HOLD extend the hold.
module servo_gate_sequencer
    import servo_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int SETTLE_CYCLES = SERVO_SETTLE_CYCLES,
    parameter int HOLD_CYCLES   = SERVO_HOLD_CYCLES,
    parameter int TIMER_W       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            close_now,
    output logic [NREQ-1:0] ack,
    output logic            pos_sel,
    output logic            busy,
    output logic            done,
    output logic [ST_W-1:0] state_o
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(HOLD_CYCLES - 1);

    servo_state_t     state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_next;
    logic [NREQ-1:0]  ack_next;
    logic             pos_sel_next, done_next, busy_next;

    logic             arb_en;
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDX_W(IDX_W)
    ) u_arb (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .enable     (arb_en),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLOSED;
            timer   <= '0;
            rr_ptr  <= IDX_W'(NREQ - 1);
            ack     <= '0;
            pos_sel <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            rr_ptr  <= rr_ptr_next;
            ack     <= ack_next;
            pos_sel <= pos_sel_next;
            done    <= done_next;
            busy    <= busy_next;
        end
    end

    // The timer only counts down while nonzero, so it can never wrap.
    always_comb begin
        state_next   = state;
        timer_next   = (timer != '0) ? timer - TIMER_W'(1) : timer;
        rr_ptr_next  = rr_ptr;
        ack_next     = '0;
        pos_sel_next = pos_sel;
        done_next    = 1'b0;
        arb_en       = 1'b0;

        case (state)
            CLOSED: begin
                arb_en = !close_now;
                if (grant_valid) begin
                    ack_next     = grant;
                    rr_ptr_next  = grant_idx;
                    pos_sel_next = 1'b1;
                    timer_next   = SETTLE_LOAD;
                    state_next   = OPENING;
                end
            end
            OPENING: begin
                if (close_now) begin
                    pos_sel_next = 1'b0;
                    timer_next   = SETTLE_LOAD;
                    state_next   = CLOSING;
                end else if (timer == '0) begin
                    timer_next = HOLD_LOAD;
                    state_next = OPEN_HOLD;
                end
            end
            OPEN_HOLD: begin
`ifdef SERVO_SEQ_RETRIGGER_EN
                arb_en = !close_now;
`endif
                // Force-close wins, then a retrigger, then normal hold expiry.
                if (close_now) begin
                    pos_sel_next = 1'b0;
                    timer_next   = SETTLE_LOAD;
                    state_next   = CLOSING;
                end else if (grant_valid) begin
                    ack_next    = grant;
                    rr_ptr_next = grant_idx;
                    timer_next  = HOLD_LOAD;
                end else if (timer == '0) begin
                    pos_sel_next = 1'b0;
                    timer_next   = SETTLE_LOAD;
                    state_next   = CLOSING;
                end
            end
            CLOSING: begin
                if (timer == '0) begin
                    done_next  = 1'b1;
                    state_next = CLOSED;
                end
            end
            default: state_next = CLOSED;
        endcase

        busy_next = (state_next != CLOSED);
    end

    assign state_o = state;

endmodule

// File: tb/tb_servo_gate_sequencer.sv
// Randomized and directed bench for servo_gate_sequencer against a timeline model.
// Honours SERVO_SEQ_RETRIGGER_EN the same way the design does.
module tb_servo_gate_sequencer;

    localparam int NREQ = 2;
    localparam int S    = 4;
    localparam int H    = 10;
`ifdef SERVO_SEQ_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic            close_now;
    logic [NREQ-1:0] ack;
    logic            pos_sel, busy, done;
    logic [1:0]      state_o;

    servo_gate_sequencer #(
        .NREQ(NREQ), .SETTLE_CYCLES(S), .HOLD_CYCLES(H), .TIMER_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .close_now(close_now),
        .ack(ack), .pos_sel(pos_sel), .busy(busy), .done(done), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Timeline model: ages count cycles since pos_sel rose / fell.
    bit  m_open, m_closing;
    int  m_age, m_end, m_close_age, m_last;
    logic [NREQ-1:0] e_ack;
    logic e_pos, e_done, e_busy;
    logic [1:0] e_state;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int rrPick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void modelReset();
        m_open = 0; m_closing = 0; m_age = 0; m_end = 0; m_close_age = 0;
        m_last = NREQ - 1;
        e_ack = '0; e_pos = 0; e_done = 0; e_busy = 0; e_state = 2'd0;
    endfunction

    function automatic void modelStep(input logic [NREQ-1:0] r, input logic cn);
        int w;
        e_ack  = '0;
        e_done = 0;
        if (m_closing) begin
            m_close_age++;
            if (m_close_age == S) begin
                m_closing = 0;
                e_done    = 1;
            end
        end else if (m_open) begin
            m_age++;
            if (cn) begin
                m_open = 0; m_closing = 1; m_close_age = 0;
            end else if (RETRIG && m_age > S && r != '0) begin
                w = rrPick(r, m_last);
                e_ack[w] = 1'b1;
                m_last   = w;
                m_end    = m_age + H;
            end else if (m_age == m_end) begin
                m_open = 0; m_closing = 1; m_close_age = 0;
            end
        end else if (r != '0 && !cn) begin
            w = rrPick(r, m_last);
            e_ack[w] = 1'b1;
            m_last   = w;
            m_open   = 1;
            m_age    = 0;
            m_end    = S + H;
        end
        e_pos   = m_open;
        e_state = m_closing ? 2'd3 : (m_open ? ((m_age < S) ? 2'd1 : 2'd2) : 2'd0);
        e_busy  = (e_state != 2'd0);
    endfunction

    // Called at a negedge; drives one cycle and compares every output.
    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic cn);
        req       = r;
        close_now = cn;
        @(posedge clk);
        modelStep(r, cn);
        #1;
        checkOutput("ack", 32'(ack), 32'(e_ack));
        checkOutput("pos_sel", 32'(pos_sel), 32'(e_pos));
        checkOutput("busy", 32'(busy), 32'(e_busy));
        checkOutput("done", 32'(done), 32'(e_done));
        checkOutput("state_o", 32'(state_o), 32'(e_state));
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0; req = '0; close_now = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_pos_sel", 32'(pos_sel), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_state", 32'(state_o), 32'd0);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int high, gap, ng;
    bit seen_done, fell, acked;
    logic [NREQ-1:0] r;
    int grant_log[4];
    logic [NREQ-1:0] pending;

    initial begin
        rst_n = 1'b0; req = '0; close_now = 1'b0;
        modelReset();
        @(negedge clk);
        doReset();

        // Single request: open time and closing settle.
        applyStimulus(2'b01, 1'b0);
        checkOutput("single_ack", 32'(ack), 32'd1);
        high = 1; gap = 0; seen_done = 0;
        for (int i = 0; i < 60 && !seen_done; i++) begin
            applyStimulus(2'b00, 1'b0);
            if (done) seen_done = 1;
            else if (!pos_sel) gap++;
            else high++;
        end
        checkOutput("single_done_seen", 32'(seen_done), 32'd1);
        checkOutput("single_high", 32'(high), 32'(S + H));
        checkOutput("single_gap", 32'(gap), 32'(S));
        applyStimulus(2'b00, 1'b0);
        checkOutput("single_busy_after", 32'(busy), 32'd0);

        // Round-robin alternation from reset.
        doReset();
        r = 2'b11; ng = 0;
        for (int i = 0; i < 200 && ng < 4; i++) begin
            applyStimulus(r, 1'b0);
            if (ack != '0) begin
                grant_log[ng] = ack[1] ? 1 : 0;
                ng++;
                r = r & ~ack;
            end else if (r == '0) begin
                r = 2'b11;
            end
        end
        checkOutput("rr_count", 32'(ng), 32'd4);
        checkOutput("rr_g0", 32'(grant_log[0]), 32'd0);
        checkOutput("rr_g1", 32'(grant_log[1]), 32'd1);
        checkOutput("rr_g2", 32'(grant_log[2]), 32'd0);
        checkOutput("rr_g3", 32'(grant_log[3]), 32'd1);

        // Force close on the 4th OPEN_HOLD cycle.
        doReset();
        applyStimulus(2'b01, 1'b0);
        high = 1;
        for (int i = 0; i < S + 3; i++) begin
            applyStimulus(2'b00, 1'b0);
            if (pos_sel) high++;
        end
        applyStimulus(2'b00, 1'b1);
        if (pos_sel) high++;
        checkOutput("fc_high", 32'(high), 32'(S + 3 + 1));
        gap = 1; seen_done = 0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            applyStimulus(2'b00, 1'b0);
            if (done) seen_done = 1;
            else gap++;
        end
        checkOutput("fc_gap", 32'(gap), 32'(S));

        // Grant blocked while close_now is held in CLOSED.
        doReset();
        repeat (5) applyStimulus(2'b01, 1'b1);
        checkOutput("blk_ack", 32'(ack), 32'd0);
        checkOutput("blk_pos", 32'(pos_sel), 32'd0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("blk_release_ack", 32'(ack), 32'd1);
        checkOutput("blk_release_pos", 32'(pos_sel), 32'd1);

        // Request during the 8th OPEN_HOLD cycle.
        doReset();
        applyStimulus(2'b01, 1'b0);
        high = 1; fell = 0; acked = 0;
        for (int i = 0; i < S + 7; i++) begin
            applyStimulus(2'b00, 1'b0);
            if (pos_sel) high++;
        end
        r = 2'b01;
        for (int i = 0; i < 100 && !(fell && acked); i++) begin
            applyStimulus(r, 1'b0);
            if (ack != '0) begin acked = 1; r = '0; end
            if (!fell && pos_sel) high++;
            else fell = 1;
        end
        checkOutput("rt_acked", 32'(acked), 32'd1);
        checkOutput("rt_high", 32'(high), RETRIG ? 32'(S + 8 + H) : 32'(S + H));

        // Async reset in the middle of OPEN_HOLD.
        doReset();
        applyStimulus(2'b01, 1'b0);
        repeat (S + 3) applyStimulus(2'b00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_pos_sel", 32'(pos_sel), 32'd0);
        checkOutput("ar_busy", 32'(busy), 32'd0);
        checkOutput("ar_state", 32'(state_o), 32'd0);
        checkOutput("ar_done", 32'(done), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) applyStimulus(2'b00, 1'b0);

        // Randomized level requesters with occasional force-close.
        doReset();
        pending = '0;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < NREQ; b++) begin
                if (!pending[b] && $urandom_range(0, 3) == 0) pending[b] = 1'b1;
                else if (pending[b] && $urandom_range(0, 15) == 0) pending[b] = 1'b0;
            end
            applyStimulus(pending, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
            pending = pending & ~e_ack;
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
